// File: rtl/count_down_ctrl.sv
// Control FSM for the 1 kHz count-down timer: preset editing, run/pause/clear,
// and ring handling with buzzer and blink strobes. All outputs are registered.
module count_down_ctrl #(
   parameter int RING_MS  = 10000,
   parameter int BLINK_MS = 500
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_mode,
   input  logic       key_sel,
   input  logic       key_inc,
   input  logic       key_dec,
   input  logic       key_start,
   input  logic       key_clear,
   input  logic       ring_in,
   output logic       load,
   output logic       clock_en,
   output logic [7:0] hour_bcd_out,
   output logic [7:0] minute_bcd_out,
   output logic [7:0] second_bcd_out,
   output logic [1:0] field_sel,
   output logic       blink,
   output logic       buzzer,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SET   = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_RING  = 3'd4
   } state_t;

   localparam int RW = $clog2(RING_MS + 1);
   localparam int BW = $clog2(BLINK_MS + 1);
   localparam logic [RW-1:0] RING_LAST  = RW'(RING_MS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);

   state_t        state_q, state_d;
   logic [7:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;
   logic [1:0]    fsel_q, fsel_d;
   logic          load_q, load_d, cen_q, cen_d, blink_q, blink_d, buzz_q, buzz_d;
   logic          ring_q;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          ring_rise, any_key, preset_nz;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
      if (v == maxv)          return 8'h00;
      else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      else                    return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] maxv);
      if (v == 8'h00)          return maxv;
      else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
      else                     return {v[7:4], v[3:0] - 4'd1};
   endfunction

   assign ring_rise = ring_in & ~ring_q;
   assign any_key   = key_mode | key_sel | key_inc | key_dec | key_start | key_clear;
   assign preset_nz = |{hour_q, min_q, sec_q};

   always_comb begin
      state_d = state_q;
      hour_d  = hour_q;
      min_d   = min_q;
      sec_d   = sec_q;
      fsel_d  = fsel_q;
      load_d  = 1'b0;
      rcnt_d  = rcnt_q;
      bcnt_d  = bcnt_q;
      blink_d = blink_q;
      case (state_q)
         S_IDLE: begin
            if (key_clear) begin
               state_d = S_IDLE;
            end else if (key_start) begin
               if (preset_nz) begin
                  state_d = S_RUN;
                  load_d  = 1'b1;
               end
            end else if (key_mode) begin
               state_d = S_SET;
               fsel_d  = 2'd0;
            end
         end
         S_SET: begin
            if (key_clear || key_mode) begin
               state_d = S_IDLE;
               load_d  = 1'b1;
            end else if (key_sel) begin
               fsel_d = (fsel_q == 2'd2) ? 2'd0 : fsel_q + 2'd1;
            end else if (key_inc) begin
               case (fsel_q)
                  2'd0:    sec_d  = bcd_inc(sec_q, 8'h59);
                  2'd1:    min_d  = bcd_inc(min_q, 8'h59);
                  default: hour_d = bcd_inc(hour_q, 8'h23);
               endcase
            end else if (key_dec) begin
               case (fsel_q)
                  2'd0:    sec_d  = bcd_dec(sec_q, 8'h59);
                  2'd1:    min_d  = bcd_dec(min_q, 8'h59);
                  default: hour_d = bcd_dec(hour_q, 8'h23);
               endcase
            end
         end
         S_RUN: begin
            if (ring_rise) begin
               state_d = S_RING;
            end else if (key_clear) begin
               state_d = S_IDLE;
               load_d  = 1'b1;
            end else if (key_start) begin
               state_d = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (key_clear) begin
               state_d = S_IDLE;
               load_d  = 1'b1;
            end else if (key_start) begin
               state_d = S_RUN;
            end
         end
         S_RING: begin
            if (any_key || rcnt_q == RING_LAST) begin
               state_d = S_IDLE;
               load_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Counters and blink restart on every state entry; first RUN cycle after load stays disabled.
      cen_d  = (state_d == S_RUN) && !load_d;
      buzz_d = (state_d == S_RING);
      if (state_d != state_q) begin
         bcnt_d  = '0;
         blink_d = 1'b0;
         rcnt_d  = '0;
      end else if (state_q == S_SET || state_q == S_RING) begin
         if (bcnt_q == BLINK_LAST) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
         end else begin
            bcnt_d = bcnt_q + BW'(1);
         end
         if (state_q == S_RING && rcnt_q != RING_LAST) rcnt_d = rcnt_q + RW'(1);
      end else begin
         bcnt_d  = '0;
         blink_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         hour_q  <= 8'h00;
         min_q   <= 8'h00;
         sec_q   <= 8'h00;
         fsel_q  <= 2'd0;
         load_q  <= 1'b0;
         cen_q   <= 1'b0;
         blink_q <= 1'b0;
         buzz_q  <= 1'b0;
         ring_q  <= 1'b0;
         rcnt_q  <= '0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         hour_q  <= hour_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         fsel_q  <= fsel_d;
         load_q  <= load_d;
         cen_q   <= cen_d;
         blink_q <= blink_d;
         buzz_q  <= buzz_d;
         ring_q  <= ring_in;
         rcnt_q  <= rcnt_d;
         bcnt_q  <= bcnt_d;
      end
   end

   assign load           = load_q;
   assign clock_en       = cen_q;
   assign hour_bcd_out   = hour_q;
   assign minute_bcd_out = min_q;
   assign second_bcd_out = sec_q;
   assign field_sel      = fsel_q;
   assign blink          = blink_q;
   assign buzzer         = buzz_q;
   assign state          = state_q;

endmodule

// File: tb/tb_count_down_ctrl.sv
// Directed bench for count_down_ctrl with short ring/blink periods.
module tb_count_down_ctrl;

   localparam int RING_MS  = 20;
   localparam int BLINK_MS = 4;

   localparam logic [5:0] K_CLR   = 6'b100000;
   localparam logic [5:0] K_START = 6'b010000;
   localparam logic [5:0] K_MODE  = 6'b001000;
   localparam logic [5:0] K_SEL   = 6'b000100;
   localparam logic [5:0] K_INC   = 6'b000010;
   localparam logic [5:0] K_DEC   = 6'b000001;

   logic       clk, rst_n, ring_in;
   logic [5:0] keys;
   logic       load, clock_en, blink, buzzer;
   logic [7:0] hour_bcd_out, minute_bcd_out, second_bcd_out;
   logic [1:0] field_sel;
   logic [2:0] state;

   int tests_run = 0;
   int fails     = 0;

   count_down_ctrl #(.RING_MS(RING_MS), .BLINK_MS(BLINK_MS)) dut (
      .clk(clk), .rst_n(rst_n),
      .key_mode(keys[3]), .key_sel(keys[2]), .key_inc(keys[1]), .key_dec(keys[0]),
      .key_start(keys[4]), .key_clear(keys[5]), .ring_in(ring_in),
      .load(load), .clock_en(clock_en),
      .hour_bcd_out(hour_bcd_out), .minute_bcd_out(minute_bcd_out), .second_bcd_out(second_bcd_out),
      .field_sel(field_sel), .blink(blink), .buzzer(buzzer), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply a key vector for exactly one rising edge; returns on the following falling edge.
   task automatic pulse(input logic [5:0] k);
      keys = k;
      @(negedge clk);
      keys = '0;
   endtask

   task automatic test_reset;
      rst_n = 1'b1; keys = '0; ring_in = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if (state !== 3'd0 || load !== 1'b0 || clock_en !== 1'b0 || buzzer !== 1'b0 || blink !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl: state=%0d load=%b cen=%b buz=%b blink=%b, want 0 0 0 0 0",
                  state, load, clock_en, buzzer, blink);
      end
      tests_run++;
      if ({hour_bcd_out, minute_bcd_out, second_bcd_out} !== 24'h000000 || field_sel !== 2'd0) begin
         fails++;
         $display("FAIL reset_preset: got %h:%h:%h fsel=%0d, want 00:00:00 fsel=0",
                  hour_bcd_out, minute_bcd_out, second_bcd_out, field_sel);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_edit;
      pulse(K_MODE);
      tests_run++;
      if (state !== 3'd1 || field_sel !== 2'd0 || blink !== 1'b0) begin
         fails++;
         $display("FAIL edit_enter_set: state=%0d fsel=%0d blink=%b, want 1 0 0", state, field_sel, blink);
      end
      repeat (3) @(negedge clk);
      tests_run++;
      if (blink !== 1'b0) begin
         fails++;
         $display("FAIL blink_early: got %b want 0", blink);
      end
      @(negedge clk);
      tests_run++;
      if (blink !== 1'b1) begin
         fails++;
         $display("FAIL blink_toggle: got %b want 1", blink);
      end
      repeat (3) pulse(K_INC);
      pulse(K_SEL);
      tests_run++;
      if (field_sel !== 2'd1) begin
         fails++;
         $display("FAIL edit_sel: got %0d want 1", field_sel);
      end
      pulse(K_DEC);
      tests_run++;
      if ({hour_bcd_out, minute_bcd_out, second_bcd_out} !== 24'h005903) begin
         fails++;
         $display("FAIL edit_preset: got %h:%h:%h want 00:59:03", hour_bcd_out, minute_bcd_out, second_bcd_out);
      end
      pulse(K_MODE);
      tests_run++;
      if (state !== 3'd0 || load !== 1'b1) begin
         fails++;
         $display("FAIL edit_exit: state=%0d load=%b, want 0 1", state, load);
      end
      @(negedge clk);
      tests_run++;
      if (load !== 1'b0) begin
         fails++;
         $display("FAIL edit_load_width: load=%b want 0", load);
      end
   endtask

   task automatic test_wrap;
      pulse(K_MODE);
      repeat (3) pulse(K_DEC);
      pulse(K_DEC);
      tests_run++;
      if (second_bcd_out !== 8'h59) begin
         fails++;
         $display("FAIL wrap_sec_dec: got %h want 59", second_bcd_out);
      end
      pulse(K_INC);
      tests_run++;
      if (second_bcd_out !== 8'h00) begin
         fails++;
         $display("FAIL wrap_sec_inc: got %h want 00", second_bcd_out);
      end
      pulse(K_SEL);
      pulse(K_INC);
      tests_run++;
      if (minute_bcd_out !== 8'h00) begin
         fails++;
         $display("FAIL wrap_min_inc: got %h want 00", minute_bcd_out);
      end
      pulse(K_SEL);
      pulse(K_DEC);
      tests_run++;
      if (hour_bcd_out !== 8'h23) begin
         fails++;
         $display("FAIL wrap_hour_dec: got %h want 23", hour_bcd_out);
      end
      pulse(K_INC);
      tests_run++;
      if (hour_bcd_out !== 8'h00) begin
         fails++;
         $display("FAIL wrap_hour_inc: got %h want 00", hour_bcd_out);
      end
      pulse(K_SEL);
      tests_run++;
      if (field_sel !== 2'd0) begin
         fails++;
         $display("FAIL wrap_fsel: got %0d want 0", field_sel);
      end
      pulse(K_MODE);
   endtask

   task automatic test_start;
      @(negedge clk);
      pulse(K_START);
      tests_run++;
      if (state !== 3'd0 || load !== 1'b0) begin
         fails++;
         $display("FAIL start_zero: state=%0d load=%b, want 0 0", state, load);
      end
      pulse(K_MODE);
      pulse(K_INC);
      pulse(K_INC);
      pulse(K_MODE);
      @(negedge clk);
      pulse(K_START);
      tests_run++;
      if (state !== 3'd2 || load !== 1'b1 || clock_en !== 1'b0) begin
         fails++;
         $display("FAIL start_run: state=%0d load=%b cen=%b, want 2 1 0", state, load, clock_en);
      end
      @(negedge clk);
      tests_run++;
      if (load !== 1'b0 || clock_en !== 1'b1) begin
         fails++;
         $display("FAIL run_cen: load=%b cen=%b, want 0 1", load, clock_en);
      end
      pulse(K_START);
      tests_run++;
      if (state !== 3'd3 || clock_en !== 1'b0) begin
         fails++;
         $display("FAIL pause: state=%0d cen=%b, want 3 0", state, clock_en);
      end
      pulse(K_START);
      tests_run++;
      if (state !== 3'd2 || clock_en !== 1'b1 || load !== 1'b0) begin
         fails++;
         $display("FAIL resume: state=%0d cen=%b load=%b, want 2 1 0", state, clock_en, load);
      end
   endtask

   task automatic test_ring;
      ring_in = 1'b1;
      @(negedge clk);
      tests_run++;
      if (state !== 3'd4 || buzzer !== 1'b1 || clock_en !== 1'b0) begin
         fails++;
         $display("FAIL ring_enter: state=%0d buz=%b cen=%b, want 4 1 0", state, buzzer, clock_en);
      end
      for (int i = 1; i < RING_MS; i++) begin
         @(negedge clk);
         if (i == 3) begin
            tests_run++;
            if (blink !== 1'b0) begin
               fails++;
               $display("FAIL ring_blink_early: got %b want 0", blink);
            end
         end
         if (i == 4) begin
            tests_run++;
            if (blink !== 1'b1) begin
               fails++;
               $display("FAIL ring_blink: got %b want 1", blink);
            end
         end
      end
      tests_run++;
      if (state !== 3'd4 || buzzer !== 1'b1) begin
         fails++;
         $display("FAIL ring_hold: state=%0d buz=%b, want 4 1", state, buzzer);
      end
      @(negedge clk);
      tests_run++;
      if (state !== 3'd0 || load !== 1'b1 || buzzer !== 1'b0 || blink !== 1'b0) begin
         fails++;
         $display("FAIL ring_timeout: state=%0d load=%b buz=%b blink=%b, want 0 1 0 0",
                  state, load, buzzer, blink);
      end
      ring_in = 1'b0;
      @(negedge clk);
      pulse(K_START);
      ring_in = 1'b1;
      @(negedge clk);
      pulse(K_INC);
      tests_run++;
      if (state !== 3'd0 || load !== 1'b1 || {hour_bcd_out, minute_bcd_out, second_bcd_out} !== 24'h000002) begin
         fails++;
         $display("FAIL ring_key_exit: state=%0d load=%b preset=%h:%h:%h, want 0 1 00:00:02",
                  state, load, hour_bcd_out, minute_bcd_out, second_bcd_out);
      end
      ring_in = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_priority;
      pulse(K_START);
      @(negedge clk);
      pulse(K_START | K_CLR);
      tests_run++;
      if (state !== 3'd0 || load !== 1'b1) begin
         fails++;
         $display("FAIL clear_wins: state=%0d load=%b, want 0 1", state, load);
      end
      pulse(K_START);
      @(negedge clk);
      ring_in = 1'b1;
      pulse(K_START);
      tests_run++;
      if (state !== 3'd4 || buzzer !== 1'b1) begin
         fails++;
         $display("FAIL ring_beats_start: state=%0d buz=%b, want 4 1", state, buzzer);
      end
      pulse(K_CLR);
      ring_in = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_midrun;
      pulse(K_START);
      @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      tests_run++;
      if (state !== 3'd0 || clock_en !== 1'b0 || load !== 1'b0 ||
          {hour_bcd_out, minute_bcd_out, second_bcd_out} !== 24'h000000) begin
         fails++;
         $display("FAIL reset_midrun: state=%0d cen=%b load=%b preset=%h:%h:%h, want 0 0 0 00:00:00",
                  state, clock_en, load, hour_bcd_out, minute_bcd_out, second_bcd_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_edit();
      test_wrap();
      test_start();
      test_ring();
      test_priority();
      test_reset_midrun();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
